// File: rtl/burst_write_master_if.sv
// Avalon-MM burst write bus between the write master and the memory controller write port.
interface burst_write_master_if #(
    parameter int unsigned ADDRESS_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned BYTE_ENABLE_WIDTH = 4,
    parameter int unsigned BURST_WIDTH       = 4
);
    logic [ADDRESS_WIDTH-1:0]     address;
    logic                         write;
    logic [DATA_WIDTH-1:0]        writedata;
    logic [BURST_WIDTH-1:0]       burstcount;
    logic [BYTE_ENABLE_WIDTH-1:0] byteenable;
    logic                         waitrequest;

    modport master (
        output address, write, writedata, burstcount, byteenable,
        input  waitrequest
    );

    modport slave (
        input  address, write, writedata, burstcount, byteenable,
        output waitrequest
    );
endinterface

// File: rtl/burst_write_master.sv
// Avalon-MM burst write master: writes a programmed word count as bursts, sourcing data
// from a first-word-fall-through stream FIFO or from an incrementing pattern generator.
module burst_write_master #(
    parameter int unsigned ADDRESS_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned BYTE_ENABLE_WIDTH = 4,
    parameter int unsigned LENGTH_WIDTH      = 24,
    parameter int unsigned MAX_BURST         = 8,
    parameter int unsigned BURST_WIDTH       = 4,
    parameter int unsigned FIFO_DEPTH        = 32,
    parameter int unsigned FIFO_DEPTH_LOG2   = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,

    input  logic                     ctrl_start,
    input  logic [ADDRESS_WIDTH-1:0] ctrl_baseaddress,
    input  logic [LENGTH_WIDTH-1:0]  ctrl_length,
    input  logic                     ctrl_pattern_mode,
    input  logic [DATA_WIDTH-1:0]    ctrl_seed,
    output logic                     ctrl_busy,
    output logic                     ctrl_done,

    input  logic                     user_write,
    input  logic [DATA_WIDTH-1:0]    user_writedata,
    output logic                     user_buffer_full,

    burst_write_master_if.master     master
);
    localparam int unsigned BE_SHIFT    = $clog2(BYTE_ENABLE_WIDTH);
    localparam int unsigned LEVEL_WIDTH = FIFO_DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        BURST,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDRESS_WIDTH-1:0]   addr;
    logic [LENGTH_WIDTH-1:0]    remaining;
    logic                       pattern_mode;
    logic [DATA_WIDTH-1:0]      pattern;
    logic [BURST_WIDTH-1:0]     beats_left;

    logic [DATA_WIDTH-1:0]      mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [LEVEL_WIDTH-1:0]     level;
    logic [LEVEL_WIDTH-1:0]     level_next;

    logic [BURST_WIDTH-1:0]     burst_len_c;
    logic                       data_ready_c;
    logic                       start_c;
    logic                       load_c;
    logic                       accept_c;
    logic                       last_beat_c;
    logic                       push_c;
    logic                       pop_c;
    logic [DATA_WIDTH-1:0]      next_word_c;

    assign master.byteenable = '1;

    // Burst sizing and source readiness for the arbitration state
    always_comb begin
        burst_len_c  = BURST_WIDTH'(MAX_BURST);
        if (remaining < LENGTH_WIDTH'(MAX_BURST)) begin
            burst_len_c = BURST_WIDTH'(remaining);
        end
        data_ready_c = pattern_mode || (level >= LEVEL_WIDTH'(burst_len_c));
        accept_c     = master.write && !master.waitrequest;
        last_beat_c  = accept_c && (beats_left == BURST_WIDTH'(1));
        next_word_c  = pattern_mode ? pattern : mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Zero length falls through ARB to DONE without ever raising write
    always_comb begin
        state_next = state;
        start_c    = 1'b0;
        load_c     = 1'b0;
        unique case (state)
            IDLE: begin
                if (ctrl_start) begin
                    start_c    = 1'b1;
                    state_next = ARB;
                end
            end
            ARB: begin
                if (remaining == '0) begin
                    state_next = DONE;
                end else if (data_ready_c) begin
                    load_c     = 1'b1;
                    state_next = BURST;
                end
            end
            BURST: begin
                if (last_beat_c) begin
                    state_next = (remaining == LENGTH_WIDTH'(master.burstcount)) ? DONE : ARB;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Writedata is a register, so the first word is popped at burst load and each later
    // word on the acceptance of the previous one; the last acceptance pops nothing.
    assign push_c = user_write && !user_buffer_full;
    assign pop_c  = !pattern_mode && (load_c || (accept_c && !last_beat_c));

    always_comb begin
        level_next = level;
        unique case ({push_c, pop_c})
            2'b10:   level_next = level + LEVEL_WIDTH'(1);
            2'b01:   level_next = level - LEVEL_WIDTH'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= user_writedata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            level            <= '0;
            user_buffer_full <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + FIFO_DEPTH_LOG2'(1);
            end
            level            <= level_next;
            user_buffer_full <= (level_next == LEVEL_WIDTH'(FIFO_DEPTH));
        end
    end

    // Transfer bookkeeping and registered bus outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr              <= '0;
            remaining         <= '0;
            pattern_mode      <= 1'b0;
            pattern           <= '0;
            beats_left        <= '0;
            ctrl_busy         <= 1'b0;
            ctrl_done         <= 1'b0;
            master.address    <= '0;
            master.write      <= 1'b0;
            master.writedata  <= '0;
            master.burstcount <= '0;
        end else begin
            ctrl_done <= (state == DONE);
            if (state == DONE) begin
                ctrl_busy <= 1'b0;
            end

            if (start_c) begin
                addr         <= ctrl_baseaddress;
                remaining    <= ctrl_length;
                pattern_mode <= ctrl_pattern_mode;
                pattern      <= ctrl_seed;
                ctrl_busy    <= 1'b1;
            end

            if (load_c) begin
                master.write      <= 1'b1;
                master.address    <= addr;
                master.burstcount <= burst_len_c;
                master.writedata  <= next_word_c;
                beats_left        <= burst_len_c;
                if (pattern_mode) begin
                    pattern <= pattern + DATA_WIDTH'(1);
                end
            end

            if (accept_c) begin
                if (last_beat_c) begin
                    master.write <= 1'b0;
                    addr         <= addr + (ADDRESS_WIDTH'(master.burstcount) << BE_SHIFT);
                    remaining    <= remaining - LENGTH_WIDTH'(master.burstcount);
                end else begin
                    beats_left       <= beats_left - BURST_WIDTH'(1);
                    master.writedata <= next_word_c;
                    if (pattern_mode) begin
                        pattern <= pattern + DATA_WIDTH'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_burst_write_master.sv
// Scoreboard bench for burst_write_master: directed transfers queue expected beats and
// done events; a negedge monitor pops and compares every accepted beat and done pulse.
module tb_burst_write_master;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned BEW = 4;
    localparam int unsigned LW  = 24;
    localparam int unsigned MB  = 8;
    localparam int unsigned BW  = 4;
    localparam int unsigned FD  = 32;
    localparam int unsigned FDL = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ctrl_start = 1'b0;
    logic [AW-1:0] ctrl_baseaddress = '0;
    logic [LW-1:0] ctrl_length = '0;
    logic          ctrl_pattern_mode = 1'b0;
    logic [DW-1:0] ctrl_seed = '0;
    logic          ctrl_busy;
    logic          ctrl_done;
    logic          user_write = 1'b0;
    logic [DW-1:0] user_writedata = '0;
    logic          user_buffer_full;

    always #5 clk = ~clk;

    burst_write_master_if #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_ENABLE_WIDTH(BEW), .BURST_WIDTH(BW)
    ) bus ();

    burst_write_master #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_ENABLE_WIDTH(BEW), .LENGTH_WIDTH(LW),
        .MAX_BURST(MB), .BURST_WIDTH(BW), .FIFO_DEPTH(FD), .FIFO_DEPTH_LOG2(FDL)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ctrl_start(ctrl_start),
        .ctrl_baseaddress(ctrl_baseaddress),
        .ctrl_length(ctrl_length),
        .ctrl_pattern_mode(ctrl_pattern_mode),
        .ctrl_seed(ctrl_seed),
        .ctrl_busy(ctrl_busy),
        .ctrl_done(ctrl_done),
        .user_write(user_write),
        .user_writedata(user_writedata),
        .user_buffer_full(user_buffer_full),
        .master(bus)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [BW-1:0] bc;
        logic [DW-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    done_q[$];
    int    errors = 0;
    int    checks = 0;
    int    done_count = 0;
    int    done_target = 0;
    int    beat_count = 0;
    int    since_accept = 0;
    int    pushed = 0;
    int    wr_mode = 0;
    logic  prev_stall = 1'b0;
    beat_t prev_beat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Slave stall generator: 0 = never stall, 1 = random 50%, 2 = always stall
    always @(posedge clk) begin
        #2;
        case (wr_mode)
            0:       bus.waitrequest = 1'b0;
            1:       bus.waitrequest = 1'($urandom_range(0, 1));
            default: bus.waitrequest = 1'b1;
        endcase
    end

    // A beat seen here with waitrequest low is accepted at the following rising edge
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        int    exp_words;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            cur.addr = bus.address;
            cur.bc   = bus.burstcount;
            cur.data = bus.writedata;
            since_accept++;
            if (prev_stall) begin
                check("stall_write_held", 64'(bus.write), 64'd1);
                check("stall_address_stable", 64'(cur.addr), 64'(prev_beat.addr));
                check("stall_burstcount_stable", 64'(cur.bc), 64'(prev_beat.bc));
                check("stall_writedata_stable", 64'(cur.data), 64'(prev_beat.data));
            end
            if (ctrl_done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got ctrl_done=1, expected 0");
                end else begin
                    exp_words = done_q.pop_front();
                    check("done_word_count", 64'(beat_count), 64'(exp_words));
                    check("done_clears_busy", 64'(ctrl_busy), 64'd0);
                    if (exp_words > 0) check("done_latency", 64'(since_accept), 64'd2);
                end
                beat_count = 0;
                done_count++;
            end
            if (bus.write && !bus.waitrequest) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0h data=%0h, expected no write",
                             bus.address, bus.writedata);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_address", 64'(bus.address), 64'(e.addr));
                    check("beat_burstcount", 64'(bus.burstcount), 64'(e.bc));
                    check("beat_writedata", 64'(bus.writedata), 64'(e.data));
                end
                beat_count++;
                since_accept = 0;
            end
            prev_stall = bus.write && bus.waitrequest;
            prev_beat  = cur;
        end
    end

    // Expected beats of a pattern transfer: bursts of up to MB, data seed, seed+1, ...
    task automatic expect_pattern(input logic [AW-1:0] base, input int len, input logic [DW-1:0] seed);
        beat_t e;
        for (int i = 0; i < len; i++) begin
            int bstart;
            bstart = (i / MB) * MB;
            e.addr = base + AW'(bstart * BEW);
            e.bc   = BW'(((len - bstart) < MB) ? (len - bstart) : MB);
            e.data = seed + DW'(i);
            exp_q.push_back(e);
        end
        done_q.push_back(len);
        done_target++;
    endtask

    task automatic start_xfer(input logic [AW-1:0] base, input int len, input logic pmode,
                              input logic [DW-1:0] seed);
        @(posedge clk);
        #2;
        ctrl_baseaddress  = base;
        ctrl_length       = LW'(len);
        ctrl_pattern_mode = pmode;
        ctrl_seed         = seed;
        ctrl_start        = 1'b1;
        @(posedge clk);
        #2;
        ctrl_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_count < done_target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", 64'(done_count >= done_target), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        beat_t e;
        int    n;
        bus.waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_write", 64'(bus.write), 64'd0);
        check("reset_address", 64'(bus.address), 64'd0);
        check("reset_burstcount", 64'(bus.burstcount), 64'd0);
        check("reset_writedata", 64'(bus.writedata), 64'd0);
        check("reset_byteenable", 64'(bus.byteenable), 64'hF);
        check("reset_busy", 64'(ctrl_busy), 64'd0);
        check("reset_done", 64'(ctrl_done), 64'd0);
        check("reset_full", 64'(user_buffer_full), 64'd0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Single full burst from the pattern generator
        expect_pattern(32'h1000, 8, 32'd19);
        start_xfer(32'h1000, 8, 1'b1, 32'd19);
        @(negedge clk);
        check("busy_after_start", 64'(ctrl_busy), 64'd1);
        wait_done(100);

        // 8/8/3 bursts with a start pulse issued mid-transfer that must be ignored
        expect_pattern(32'h2000, 19, 32'd100);
        start_xfer(32'h2000, 19, 1'b1, 32'd100);
        repeat (4) @(posedge clk);
        #2;
        ctrl_baseaddress = 32'h9000;
        ctrl_length      = LW'(5);
        ctrl_start       = 1'b1;
        @(posedge clk);
        #2;
        ctrl_start = 1'b0;
        wait_done(200);

        // Random stalls with a pattern that wraps through zero
        wr_mode = 1;
        expect_pattern(32'h3000, 8, 32'hFFFF_FFFE);
        start_xfer(32'h3000, 8, 1'b1, 32'hFFFF_FFFE);
        wait_done(300);
        wr_mode = 0;

        // Address wraps from the top of the space into the second burst
        expect_pattern(32'hFFFF_FFE0, 12, 32'h55);
        start_xfer(32'hFFFF_FFE0, 12, 1'b1, 32'h55);
        wait_done(200);

        // FIFO mode fed one word every three cycles; first write only once 8 are buffered
        done_q.push_back(16);
        done_target++;
        pushed = 0;
        start_xfer(32'h4000, 16, 1'b0, 32'd0);
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    @(posedge clk);
                    #2;
                    user_write     = 1'b1;
                    user_writedata = 32'hA000 + DW'(i);
                    e.addr = 32'h4000 + AW'((i / MB) * MB * BEW);
                    e.bc   = BW'(MB);
                    e.data = 32'hA000 + DW'(i);
                    exp_q.push_back(e);
                    pushed = i + 1;
                    @(posedge clk);
                    #2;
                    user_write = 1'b0;
                    @(posedge clk);
                end
            end
            begin
                n = 0;
                while (!bus.write && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                check("fifo_first_write_seen", 64'(bus.write), 64'd1);
                check("fifo_words_before_write", 64'(pushed), 64'd8);
            end
        join
        wait_done(300);

        // Prefill to full while idle; the extra push is dropped
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #2;
            user_write     = 1'b1;
            user_writedata = 32'hB000 + DW'(i);
            if (i == 31) begin
                @(negedge clk);
                check("not_full_at_31", 64'(user_buffer_full), 64'd0);
            end
        end
        @(posedge clk);
        #2;
        user_write = 1'b0;
        @(negedge clk);
        check("full_at_32", 64'(user_buffer_full), 64'd1);
        @(posedge clk);
        #2;
        user_write     = 1'b1;
        user_writedata = 32'hDEAD;
        @(posedge clk);
        #2;
        user_write = 1'b0;
        @(negedge clk);
        check("full_after_drop", 64'(user_buffer_full), 64'd1);
        for (int i = 0; i < 32; i++) begin
            e.addr = 32'h5000 + AW'((i / MB) * MB * BEW);
            e.bc   = BW'(MB);
            e.data = 32'hB000 + DW'(i);
            exp_q.push_back(e);
        end
        done_q.push_back(32);
        done_target++;
        wr_mode = 1;
        start_xfer(32'h5000, 32, 1'b0, 32'd0);
        wait_done(500);
        wr_mode = 0;
        check("fifo_drained_not_full", 64'(user_buffer_full), 64'd0);

        // Zero length: busy for two cycles, then done, never a write
        done_q.push_back(0);
        done_target++;
        @(posedge clk);
        #2;
        ctrl_length = '0;
        ctrl_start  = 1'b1;
        @(posedge clk);
        #2;
        ctrl_start = 1'b0;
        @(negedge clk);
        check("len0_busy_c1", 64'({ctrl_busy, ctrl_done}), 64'b10);
        @(negedge clk);
        check("len0_busy_c2", 64'({ctrl_busy, ctrl_done}), 64'b10);
        @(negedge clk);
        check("len0_done", 64'({ctrl_busy, ctrl_done}), 64'b01);
        repeat (2) @(negedge clk);

        // Reset during a stalled burst aborts it with no done pulse
        wr_mode = 2;
        start_xfer(32'h6000, 16, 1'b1, 32'd1);
        n = 0;
        while (!bus.write && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abort_burst_started", 64'(bus.write), 64'd1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("abort_write_low", 64'(bus.write), 64'd0);
        check("abort_busy_low", 64'(ctrl_busy), 64'd0);
        check("abort_burstcount", 64'(bus.burstcount), 64'd0);
        check("abort_byteenable", 64'(bus.byteenable), 64'hF);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        wr_mode = 0;
        repeat (10) @(negedge clk);
        check("abort_no_done", 64'(done_count), 64'(done_target));

        // Clean transfer after the abort
        expect_pattern(32'h7000, 3, 32'd7);
        start_xfer(32'h7000, 3, 1'b1, 32'd7);
        wait_done(100);

        check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
        check("done_queue_drained", 64'(done_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
